// File: rtl/wash_led_sched_pkg.sv
// Shared types and build constants for the stage-indicator LED scheduler.
package wash_led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Blink half-period of 1.5 s at the two supported clock builds.
  localparam int BLINK_HALF_30KHZ = 45000;
  localparam int BLINK_HALF_50MHZ = 75000000;

  function automatic int blink_half_for(input bit fast_clk);
    return fast_clk ? BLINK_HALF_50MHZ : BLINK_HALF_30KHZ;
  endfunction

endpackage

// File: rtl/wash_led_sched_if.sv
// Signal bundle between the wash-program FSM, the breathing engine and the scheduler.
interface wash_led_sched_if import wash_led_sched_pkg::*; #(
  parameter int NUM_CH = 5
) ();

  // start, stage_adv and abort are single-cycle pulses sampled on the rising
  // clock edge; pause is a level; brth_led is sampled every cycle in RUN.
  logic              start;
  logic              stage_adv;
  logic              pause;
  logic              abort;
  logic              brth_led;
  logic              brth_clr;
  logic              brth_en;
  logic [NUM_CH-1:0] led_out;
  logic              busy;
  logic              done;
  state_t            dbg_state;

  modport master (
    output start, stage_adv, pause, abort, brth_led,
    input  brth_clr, brth_en, led_out, busy, done, dbg_state
  );

  modport slave (
    input  start, stage_adv, pause, abort, brth_led,
    output brth_clr, brth_en, led_out, busy, done, dbg_state
  );

endinterface

// File: rtl/wash_led_sched_blink_timer.sv
// Blink half-period timer: counter, phase bit and half-period count for PAUSE/FINISH.
module blink_timer import wash_led_sched_pkg::*; #(
  parameter  int BLINK_HALF  = 45000,
  parameter  int DONE_BLINKS = 3,
  localparam int HW          = $clog2(2 * DONE_BLINKS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  input  logic          run,
  output logic          phase,
  output logic [HW-1:0] half_cnt,
  output logic          wrap
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic [HW-1:0] r_half;
  logic          w_last;

  assign w_last   = (r_cnt == CW'(BLINK_HALF - 1));
  // wrap marks the last cycle of the current half-period
  assign wrap     = run & w_last;
  assign phase    = r_phase;
  assign half_cnt = r_half;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
      r_half  <= '0;
    end else if (restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
      r_half  <= '0;
    end else if (run) begin
      if (w_last) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
        r_half  <= r_half + HW'(1);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/wash_led_sched.sv
// Stage-indicator LED scheduler: shares one breathing engine across the wash stage LEDs.
module wash_led_sched import wash_led_sched_pkg::*; #(
  parameter  int NUM_CH      = 5,
  parameter  int BLINK_HALF  = blink_half_for(1'b0),
  parameter  int DONE_BLINKS = 3,
  localparam int SW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int HW          = $clog2(2 * DONE_BLINKS) + 1
) (
  input logic             clk,
  input logic             rst,
  wash_led_sched_if.slave bus
);

  state_t            r_state, w_next;
  logic [SW-1:0]     r_stage, w_stage_nxt;
  logic              r_adv, w_adv;
  logic              r_fin, w_fin;
  logic              w_restart;
  logic              w_phase, w_wrap;
  logic [HW-1:0]     w_half;
  logic [NUM_CH-1:0] w_led;
  logic              w_clr, w_en, w_mark;

  blink_timer #(
    .BLINK_HALF  (BLINK_HALF),
    .DONE_BLINKS (DONE_BLINKS)
  ) u_blink (
    .clk      (clk),
    .rst      (rst),
    .restart  (w_restart),
    .run      ((r_state == PAUSE) || (r_state == FINISH)),
    .phase    (w_phase),
    .half_cnt (w_half),
    .wrap     (w_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_stage <= '0;
      r_adv   <= 1'b0;
      r_fin   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_stage <= w_stage_nxt;
      r_adv   <= w_adv;
      r_fin   <= w_fin;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_stage_nxt = r_stage;
    w_adv       = 1'b0;
    w_fin       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next      = RUN;
          w_stage_nxt = '0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          w_next = IDLE;
        end else if (bus.pause) begin
          w_next = PAUSE;
        end else if (bus.stage_adv) begin
          if (r_stage == SW'(NUM_CH - 1)) begin
            w_next = FINISH;
          end else begin
            w_stage_nxt = r_stage + SW'(1);
            w_adv       = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (bus.abort)       w_next = IDLE;
        else if (!bus.pause) w_next = RUN;
      end
      FINISH: begin
        if (bus.abort) begin
          w_next = IDLE;
        end else if (w_wrap && (w_half == HW'(2 * DONE_BLINKS - 1))) begin
          w_next = IDLE;
          w_fin  = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
    w_restart = (w_next != r_state) && ((w_next == PAUSE) || (w_next == FINISH));
  end

  // The active stage LED shows the engine in RUN and the blink phase in PAUSE.
  always_comb begin
    w_led  = '0;
    w_clr  = 1'b0;
    w_en   = 1'b0;
    w_mark = (r_state == RUN) ? bus.brth_led : w_phase;
    unique case (r_state)
      RUN, PAUSE: begin
        w_clr = (r_state == RUN) && !r_adv;
        for (int i = 0; i < NUM_CH; i++) begin
          if (SW'(i) < r_stage)       w_led[i] = 1'b1;
          else if (SW'(i) == r_stage) w_led[i] = w_mark;
        end
      end
      FINISH: begin
        w_led = {NUM_CH{w_phase}};
        w_en  = w_phase;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.brth_clr <= 1'b0;
      bus.brth_en  <= 1'b0;
      bus.led_out  <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.brth_clr <= w_clr;
      bus.brth_en  <= w_en;
      bus.led_out  <= w_led;
      bus.busy     <= (r_state != IDLE);
      bus.done     <= r_fin;
    end
  end

  assign bus.dbg_state = r_state;

endmodule
